seq_array_mul: RTL and testbench
================================

Name: seq_array_mul

Overview:
Parametrised sequential shift-add multiplier; the clocked, handshaked successor to the team's fixed 4-bit combinational array multiplier. Accepts one WIDTH x WIDTH operand pair over a valid/ready interface and computes one partial product per clock. Selects signed or unsigned per transaction. Holds the 2*WIDTH-bit product until downstream accepts it. Sits between operand-producing logic and any consumer that may apply backpressure.

Parameters:
WIDTH, 4, operand width in bits (>=2); product is 2*WIDTH bits
CNT_W, $clog2(WIDTH)+1, internal bit-counter width (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair a/b/is_signed is valid
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  WIDTH  multiplicand
b  input  WIDTH  multiplier
is_signed  input  1  1 = two's-complement operands, 0 = unsigned
out_valid  output  1  product valid; held until accepted
out_ready  input  1  consumer accepts product
s  output  2*WIDTH  product
busy  output  1  high in CALC or FIX

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (rst_n); all flops clear immediately on rst_n low.
- Reset values: in_ready=1 once rst_n deasserts, out_valid=0, s=0, busy=0, state=IDLE.
- Reset mid-operation aborts the transaction. No product is emitted. First cycle after release is IDLE.
- States: IDLE, CALC, FIX, DONE.
- IDLE: in_ready=1.
  - Accept on in_valid&&in_ready at an edge.
  - Register |a| and |b| as unsigned magnitudes when is_signed=1, raw values otherwise.
  - Register neg = is_signed & (a[MSB]^b[MSB]), clear accumulator and counter, go to CALC.
- Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) and fits in WIDTH unsigned bits. No overflow case exists.
- CALC, one edge per bit:
  - If the current multiplier LSB is 1, add the shifted multiplicand into the 2*WIDTH accumulator.
  - Shift the multiplier right by one, increment the counter.
  - After WIDTH CALC edges, go to FIX.
- FIX: one edge.
  - s <= neg ? -acc : acc, as a 2*WIDTH two's-complement result.
  - Go to DONE; out_valid=1.
- DONE: out_valid=1, s stable.
  - On out_ready=1 at an edge, go to IDLE; out_valid=0. s retains its last value.
- Latency: out_valid first high WIDTH+1 edges after the acceptance edge.
- Throughput: one product per WIDTH+3 cycles when out_ready is tied high.
- in_ready is low throughout CALC/FIX/DONE. in_valid is ignored there; a/b may change freely without effect.
- out_ready is ignored outside DONE.
- Unsigned result is exact for all inputs: max (2^WIDTH-1)^2 fits in 2*WIDTH bits.
- Signed result is exact for all inputs, including (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2).

Optional Feature:
SEQ_MUL_EARLY_TERM_EN
- Defined: CALC exits to FIX after the edge where the remaining shifted multiplier magnitude becomes zero, with a minimum of one CALC edge.
  - Latency = max(1, p+1) + 1 edges, where p is the index of the highest set bit of the magnitude of b (b=0 counts as p=0).
- Undefined: CALC always runs exactly WIDTH edges, giving fixed latency WIDTH+1.
- Product value is identical in both builds.

Test Plan:
- WIDTH=4, unsigned, a=15, b=15, out_ready=1 -> s=8'hE1 (225); out_valid high exactly 5 edges after accept, for one cycle.
- WIDTH=4, signed: a=4'b1000, b=4'b1000 -> s=8'h40 (+64). Then a=4'b1000, b=4'b0111 -> s=8'hC8 (-56). Then a=4'b1111, b=4'b0001 -> s=8'hFF (-1).
- Backpressure: a=3, b=5, out_ready=0 for 10 cycles -> out_valid and s=8'h0F held stable, in_ready=0. Raise out_ready -> out_valid drops after one edge, in_ready rises.
- Reset mid-CALC: accept a=9, b=9, pull rst_n low 2 cycles later (asynchronous, between edges) -> out_valid=0 and s=0 immediately; next accept a=2, b=3 -> s=8'h06.
- Zero and ignored-input checks: a=0, b=13 -> s=0. Toggle in_valid with new a/b during CALC -> result unaffected, no second transaction.
- With SEQ_MUL_EARLY_TERM_EN, WIDTH=8: a=200, b=1 -> s=16'h00C8 after 2 edges. b=8'h80 unsigned -> 9 edges. Without the macro, both take 9 edges.

Source files
------------

// File: rtl/seq_array_mul.sv
// Sequential shift-add multiplier, signed/unsigned per transaction, valid/ready on both sides.
// Optional SEQ_MUL_EARLY_TERM_EN: leave CALC once the remaining multiplier magnitude is zero.
module seq_array_mul #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] s,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     mplier;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [CNT_W-1:0]     cnt;
  logic                 neg;
  logic                 last;

  // -2^(WIDTH-1) negates to itself, which read unsigned is the right magnitude
  always_comb begin
    a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
    b_mag = (is_signed && b[WIDTH-1]) ? -b : b;
  end

`ifdef SEQ_MUL_EARLY_TERM_EN
  assign last = (mplier[WIDTH-1:1] == '0) ||
                (cnt == CNT_W'(WIDTH - 1));
`else
  assign last = (cnt == CNT_W'(WIDTH - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      s         <= '0;
      mplier    <= '0;
      mcand     <= '0;
      acc       <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            mcand    <= {{WIDTH{1'b0}}, a_mag};
            mplier   <= b_mag;
            neg      <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (last) state <= FIX;
        end
        FIX: begin
          s         <= neg ? -acc : acc;
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_array_mul.sv
// Scoreboard bench for seq_array_mul at WIDTH=4: directed vectors, latency,
// backpressure, asynchronous reset abort and ignored-input checks.
module tb_seq_array_mul;

  localparam int W = 4;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           is_signed;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] s;
  logic           busy;

  int checks;
  int errors;
  int pushed;
  int popped;
  logic [2*W-1:0] sbq[$];

  seq_array_mul #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .is_signed(is_signed),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .s(s),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: a product is consumed at an edge where out_valid && out_ready
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL extra_product: got %0h expected none", s);
        end else begin
          logic [2*W-1:0] e;
          e = sbq.pop_front();
          popped++;
          if (s !== e) begin
            errors++;
            $display("FAIL product: got %0h expected %0h", s, e);
          end
        end
      end
    end
  end

  function automatic int exp_lat(input logic [W-1:0] bb, input logic sg);
    logic [W-1:0] m;
    int p;
    m = (sg && bb[W-1]) ? -bb : bb;
    p = 0;
    for (int i = 0; i < W; i++) if (m[i]) p = i;
`ifdef SEQ_MUL_EARLY_TERM_EN
    return p + 2;
`else
    return W + 1;
`endif
  endfunction

  // present operands until accepted; returns after the accept edge (+1)
  task automatic issue(input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input logic sg, input logic [2*W-1:0] e);
    int n;
    a = aa;
    b = bb;
    is_signed = sg;
    in_valid = 1'b1;
    sbq.push_back(e);
    pushed++;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL out_timeout: got out_valid=0 expected 1");
    end
  endtask

  task automatic run(input logic [W-1:0] aa, input logic [W-1:0] bb,
                     input logic sg, input logic [2*W-1:0] e);
    int lat;
    issue(aa, bb, sg, e);
    wait_out(lat);
    chk("latency", lat, exp_lat(bb, sg));
    @(posedge clk);
    #1;
    chk("valid_one_cycle", {31'd0, out_valid}, 0);
    chk("hold_s", s, e);
  endtask

  initial begin
    int lat;
    checks = 0;
    errors = 0;
    pushed = 0;
    popped = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    is_signed = 1'b0;
    out_ready = 1'b1;
    #23;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_s", s, 0);
    chk("rst_busy", {31'd0, busy}, 0);

    run(4'd15, 4'd15, 1'b0, 8'hE1);
    run(4'b1000, 4'b1000, 1'b1, 8'h40);
    run(4'b1000, 4'b0111, 1'b1, 8'hC8);
    run(4'b1111, 4'b0001, 1'b1, 8'hFF);
    run(4'b1111, 4'b1111, 1'b1, 8'h01);
    run(4'd8, 4'd8, 1'b0, 8'h40);
    run(4'd12, 4'd1, 1'b0, 8'h0C);
    run(4'd0, 4'd13, 1'b0, 8'h00);

    // busy visible during CALC
    issue(4'd7, 4'd3, 1'b0, 8'h15);
    chk("busy_calc", {31'd0, busy}, 1);
    chk("in_ready_calc", {31'd0, in_ready}, 0);
    wait_out(lat);
    @(posedge clk);
    #1;

    // backpressure
    out_ready = 1'b0;
    issue(4'd3, 4'd5, 1'b0, 8'h0F);
    wait_out(lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", {31'd0, out_valid}, 1);
      chk("bp_s", s, 8'h0F);
      chk("bp_in_ready", {31'd0, in_ready}, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", {31'd0, out_valid}, 0);
    chk("bp_release_ready", {31'd0, in_ready}, 1);

    // asynchronous reset in the middle of CALC
    issue(4'd9, 4'd9, 1'b0, 8'h51);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    void'(sbq.pop_back());
    pushed--;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 0);
    chk("arst_s", s, 0);
    chk("arst_busy", {31'd0, busy}, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_idle", {31'd0, in_ready}, 1);
    run(4'd2, 4'd3, 1'b0, 8'h06);

    // new operands offered during CALC must be ignored
    issue(4'd5, 4'd6, 1'b0, 8'h1E);
    a = 4'd15;
    b = 4'd15;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 4'd9;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_out(lat);
    chk("ignored_s", s, 8'h1E);
    repeat (12) @(posedge clk);
    #1;
    chk("no_second_txn", {31'd0, out_valid}, 0);
    chk("sb_drained", sbq.size(), 0);
    chk("sb_count", popped, pushed);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
